vga_fb_scanout: RTL
===================

Name: vga_fb_scanout

Overview:
Parametrised VGA timing generator plus framebuffer read engine; successor to the fixed 640x480 VGA controller/framebuffer pair.
Walks the raster and issues framebuffer read addresses with programmable scan modes: linear, serpentine, mirrored, and built-in colour bars.
Compensates the memory read latency and drives aligned RGB888, sync and valid outputs.
Sits between the framebuffer RAM and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
PIX_W, 24, framebuffer word: 24 = RGB888, 16 = RGB565, 8 = RGB332
ADDR_W, 19, framebuffer address width
RD_LAT, 1, memory read latency in cycles (1..4)
SYNC_POL, 0, active sync level

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  scan enable
mode  in  2  0 linear, 1 serpentine, 2 h-mirror, 3 colour bars
base_addr  in  ADDR_W  framebuffer start address
mem_rd_en  out  1  read strobe
mem_addr  out  ADDR_W  read address
mem_rdata  in  PIX_W  read data, valid RD_LAT cycles after mem_addr/mem_rd_en
hsync, vsync  out  1  sync outputs
valid  out  1  active-video indicator
vga_r, vga_g, vga_b  out  8 each  pixel colour
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset values:
  - All counters 0.
  - hsync/vsync = ~SYNC_POL; valid, frame_start, mem_rd_en = 0.
  - mem_addr = 0; rgb = 0.
- Raster counters:
  - h counts 0..H_TOTAL-1; v increments on h wrap and counts 0..V_TOTAL-1.
  - hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync active likewise in v.
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
- en=0: counters held at 0; all outputs at reset values after the pipeline drains. Raising en starts at (0,0).
- mode and base_addr are latched only when counters are at (0,0). Mid-frame changes take effect next frame.
- Addressing uses no multiplier: line_base accumulates +H_ACTIVE per active line, starting from the latched base.
  - Mode 0: line_base+h.
  - Mode 1: even lines line_base+(H_ACTIVE-1-h); odd lines line_base+h.
  - Mode 2: every line line_base+(H_ACTIVE-1-h).
  - Mode 3: mem_rd_en stays 0.
  - Arithmetic wraps modulo 2^ADDR_W.
- Pipeline:
  - mem_addr/mem_rd_en are registered: presented 1 cycle after the counter position. mem_rd_en=1 only in the active region.
  - Data returns RD_LAT cycles later and is captured into the output register.
  - Total latency L = RD_LAT+2 from counter position to outputs.
  - hsync, vsync, valid and frame_start are delayed through an L-deep shift register so all outputs stay aligned.
- Colour expansion by MSB replication:
  - 565: r={d[15:11],d[15:13]}, g={d[10:5],d[10:9]}, b={d[4:0],d[4:2]}.
  - 332: r={d[7:5],d[7:5],d[7:6]}, g likewise, b={d[1:0] x4}.
- Mode 3 bars: 8 bars of width H_ACTIVE/8, tracked by a bar counter (no division). Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bars pass through the same L-cycle alignment.
- rgb is forced to 0 whenever output valid=0.
- Reset asserted mid-line: all outputs go to reset values immediately (asynchronous). After release the raster restarts at (0,0).

Decomposition:
- Package vga_pkg holds:
  - mode encodings;
  - the bar colour constants;
  - an H_TOTAL/V_TOTAL derivation function;
  - pixel-format constants.
- Sub-module vga_timing holds the h/v counters and the sync/active decode, with outputs h, v, active, hs, vs, frame0.
- Address generation, delay line and colour expansion live in the top level.

Test Plan:
Small geometry for all tests: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), RD_LAT=1, SYNC_POL=0, PIX_W=24, memory model returns data = address.
- Timing, en=1 after reset release: hsync low for 2 cycles starting 10+L cycles into each 14-cycle line. vsync low for exactly 14 cycles per 98-cycle frame. valid high 32 cycles/frame. frame_start period 98.
- Mode 0, base 0x100: line 1 mem_addr 0x108..0x10F. Output {r,g,b} equals address, L=3 cycles after each counter position.
- Mode 1, base 0x100: line 0 addresses 0x107 down to 0x100; line 1 0x108..0x10F.
- Switch mode 0->2 during line 2: current frame keeps linear addresses; next frame line 0 reads 0x107..0x100.
- Mode 3: mem_rd_en stays 0. Line pixels h0..h7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. rgb=0 during blanking.
- ADDR_W=5, base 0x1E, mode 0: line 0 addresses 0x1E, 0x1F, 0x00..0x05. Reset pulled low mid-line: hsync/vsync=1 and valid=0 in the same cycle; restart from (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA framebuffer scanout block.
//   - scan_mode_t  : scan mode encodings driven on the mode input
//   - PIX_*        : supported framebuffer word widths
//   - bar_color()  : colour of each built-in test bar, left to right
//   - raster_total(): total line/frame length from active + porch + sync widths
//   - side_t       : per-pixel sideband carried down the latency-matching delay line
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_LINEAR     = 2'd0,
    MODE_SERPENTINE = 2'd1,
    MODE_HMIRROR    = 2'd2,
    MODE_BARS       = 2'd3
  } scan_mode_t;

  localparam int PIX_RGB888 = 24;
  localparam int PIX_RGB565 = 16;
  localparam int PIX_RGB332 = 8;

  localparam int NUM_BARS = 8;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // hs/vs here are "sync asserted" flags; polarity is applied at the output register.
  typedef struct packed {
    logic        active;
    logic        hs;
    logic        vs;
    logic        frame0;
    logic        bar;
    logic [23:0] bar_rgb;
  } side_t;

endpackage

// File: rtl/vga_fb_scanout_if.sv
// vga_fb_scanout_if: framebuffer read port between the scanout engine and the RAM.
//   rd_en : read strobe (scanout -> RAM)
//   addr  : read address (scanout -> RAM)
//   rdata : read data, valid RD_LAT cycles after addr/rd_en (RAM -> scanout)
// Modports: master = scanout engine, slave = framebuffer memory.
interface vga_fb_scanout_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 24
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  rdata;

  modport master (output rd_en, output addr, input rdata);
  modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster position counters and sync/active decode.
//   clk, reset : pixel clock, asynchronous active-low reset
//   en         : scan enable; counters are held at (0,0) while low
//   h, v       : current raster position
//   active     : position is inside the visible area
//   hs, vs     : horizontal / vertical sync asserted (polarity-free)
//   frame0     : position is (0,0) of a frame
// All decoded flags are gated by en so a disabled raster looks like blanking.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_W      = 10,
  parameter int V_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           active,
  output logic           hs,
  output logic           vs,
  output logic           frame0
);

  localparam int H_TOTAL  = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [H_W-1:0] h_reg;
  logic [V_W-1:0] v_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (!en) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (int'(h_reg) == H_TOTAL - 1) begin
      h_reg <= '0;
      v_reg <= (int'(v_reg) == V_TOTAL - 1) ? '0 : v_reg + 1'b1;
    end else begin
      h_reg <= h_reg + 1'b1;
    end
  end

  assign h      = h_reg;
  assign v      = v_reg;
  assign active = en && (int'(h_reg) < H_ACTIVE) && (int'(v_reg) < V_ACTIVE);
  assign hs     = en && (int'(h_reg) >= HS_START) && (int'(h_reg) < HS_END);
  assign vs     = en && (int'(v_reg) >= VS_START) && (int'(v_reg) < VS_END);
  assign frame0 = en && (h_reg == '0) && (v_reg == '0);

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA raster generator plus framebuffer read engine.
//   clk, reset          : pixel clock, asynchronous active-low reset
//   en                  : scan enable (raster restarts at (0,0) when raised)
//   mode                : 0 linear, 1 serpentine, 2 h-mirror, 3 colour bars
//   base_addr           : framebuffer start address, sampled at frame start
//   mem                 : framebuffer read port (master side)
//   hsync, vsync        : sync outputs, active level SYNC_POL
//   valid               : active-video indicator
//   vga_r, vga_g, vga_b : RGB888 pixel colour, zero outside active video
//   frame_start         : one-cycle pulse aligned with output pixel (0,0)
// Every output lags its raster position by RD_LAT+2 cycles: one for the
// address register, RD_LAT inside the RAM, one for the output register.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_W    = 24,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  vga_fb_scanout_if.master  mem,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / NUM_BARS;
  localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  // Sideband stages before the output register; the output register is the last stage.
  localparam int SIDE_D  = RD_LAT + 1;

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           active, hs, vs, frame0;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk(clk), .reset(reset), .en(en),
    .h(h), .v(v), .active(active), .hs(hs), .vs(vs), .frame0(frame0)
  );

  // ---------------------------------------------------------------------------
  // Per-frame settings. At (0,0) the live inputs are used directly so the first
  // pixel of a frame already sees the new mode/base; elsewhere the latched copy.
  // ---------------------------------------------------------------------------
  logic              at_origin;
  scan_mode_t        mode_reg, mode_cur;
  logic [ADDR_W-1:0] line_base_reg, line_base_cur;

  assign at_origin     = (h == '0) && (v == '0);
  assign mode_cur      = at_origin ? scan_mode_t'(mode) : mode_reg;
  assign line_base_cur = at_origin ? base_addr : line_base_reg;

  // line_base advances by one line width at the end of each active line,
  // replacing the v*H_ACTIVE product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg      <= MODE_LINEAR;
      line_base_reg <= '0;
    end else if (at_origin) begin
      mode_reg      <= mode_cur;
      line_base_reg <= base_addr;
    end else if ((int'(h) == H_TOTAL - 1) && (int'(v) < V_ACTIVE)) begin
      line_base_reg <= line_base_reg + ADDR_W'(H_ACTIVE);
    end
  end

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] h_fwd, h_rev, addr_next;
  logic              reverse, rd_next;

  always_comb begin
    h_fwd = ADDR_W'(h);
    h_rev = ADDR_W'(H_ACTIVE - 1) - h_fwd;
    case (mode_cur)
      MODE_SERPENTINE: reverse = ~v[0];
      MODE_HMIRROR:    reverse = 1'b1;
      default:         reverse = 1'b0;
    endcase
    addr_next = line_base_cur + (reverse ? h_rev : h_fwd);
    rd_next   = active && (mode_cur != MODE_BARS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem.rd_en <= 1'b0;
      mem.addr  <= '0;
    end else begin
      mem.rd_en <= rd_next;
      mem.addr  <= rd_next ? addr_next : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Colour bars: a pixel-within-bar counter and a bar index track h, so no
  // divide by bar width is needed.
  // ---------------------------------------------------------------------------
  logic [BP_W-1:0] bar_px_reg;
  logic [2:0]      bar_idx_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
    end else if (!en || (int'(h) == H_TOTAL - 1)) begin
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
    end else if (bar_px_reg == BP_W'(BAR_W - 1)) begin
      bar_px_reg  <= '0;
      bar_idx_reg <= bar_idx_reg + 3'd1;
    end else begin
      bar_px_reg  <= bar_px_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sideband delay line, matched to the address register plus RAM latency.
  // ---------------------------------------------------------------------------
  side_t side_in;
  side_t side_pipe [SIDE_D];
  side_t side_tail;

  always_comb begin
    side_in         = '0;
    side_in.active  = active;
    side_in.hs      = hs;
    side_in.vs      = vs;
    side_in.frame0  = frame0;
    side_in.bar     = (mode_cur == MODE_BARS);
    side_in.bar_rgb = bar_color(bar_idx_reg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIDE_D; i++) side_pipe[i] <= '0;
    end else begin
      side_pipe[0] <= side_in;
      for (int i = 1; i < SIDE_D; i++) side_pipe[i] <= side_pipe[i-1];
    end
  end

  assign side_tail = side_pipe[SIDE_D-1];

  // ---------------------------------------------------------------------------
  // Colour expansion to RGB888 by MSB replication
  // ---------------------------------------------------------------------------
  logic [23:0] pix_rgb;

  generate
    if (PIX_W == PIX_RGB888) begin : g_rgb888
      assign pix_rgb = mem.rdata;
    end else if (PIX_W == PIX_RGB565) begin : g_rgb565
      assign pix_rgb = {mem.rdata[15:11], mem.rdata[15:13],
                        mem.rdata[10:5],  mem.rdata[10:9],
                        mem.rdata[4:0],   mem.rdata[4:2]};
    end else begin : g_rgb332
      assign pix_rgb = {mem.rdata[7:5], mem.rdata[7:5], mem.rdata[7:6],
                        mem.rdata[4:2], mem.rdata[4:2], mem.rdata[4:3],
                        {4{mem.rdata[1:0]}}};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync                 <= ~SYNC_POL;
      vsync                 <= ~SYNC_POL;
      valid                 <= 1'b0;
      frame_start           <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      hsync       <= side_tail.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= side_tail.vs ? SYNC_POL : ~SYNC_POL;
      valid       <= side_tail.active;
      frame_start <= side_tail.frame0;
      if (!side_tail.active)
        {vga_r, vga_g, vga_b} <= '0;
      else if (side_tail.bar)
        {vga_r, vga_g, vga_b} <= side_tail.bar_rgb;
      else
        {vga_r, vga_g, vga_b} <= pix_rgb;
    end
  end

endmodule
